// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI4-Lite read arbiter.
//   arb_state_t : arbiter FSM states
//   master_id_t : master index (0 = I-cache, 1 = D-cache)
//   RESP_*      : AXI read response encodings
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  typedef logic [0:0] master_id_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational 2-way grant selection.
// Build option: AXI_ARB_RR_EN
//   defined   : round-robin, the master not granted last wins a tie
//   undefined : fixed priority, master 1 wins a tie (no last-granted input)
// Ports:
//   req       : request vector {m1, m0}
//   last      : last-granted master (round-robin build only)
//   gnt_valid : at least one request present
//   gnt_id    : winning master
module rr_arbiter2
  import axi_arb_pkg::*;
(
  input  logic [1:0] req,
`ifdef AXI_ARB_RR_EN
  input  master_id_t last,
`endif
  output logic       gnt_valid,
  output master_id_t gnt_id
);

  assign gnt_valid = |req;

`ifdef AXI_ARB_RR_EN
  // On a tie the other master gets its turn; a lone request always wins.
  assign gnt_id = (req == 2'b11) ? ~last : req[1];
`else
  assign gnt_id = req[1];
`endif

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-master AXI4-Lite read-channel arbiter in front of a single memory read port.
// One transaction in flight at a time: IDLE (arbitrate/accept) -> ADDR (issue to
// memory) -> DATA (route the beat back) -> IDLE.
// Build option: AXI_ARB_RR_EN selects round-robin tie breaking (default: fixed
// priority to master 1).
// Ports:
//   aclk, areset               : clock, asynchronous active-low reset
//   m0_ar*, m0_r*              : master 0 (I-cache) read address / data channels
//   m1_ar*, m1_r*              : master 1 (D-cache) read address / data channels
//   s_ar*, s_r*                : memory-side read address / data channels
//   busy                       : transaction in progress
//   grant                      : current or last granted master
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,

  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  input  logic [2:0]            m0_arprot,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]            m0_rresp,

  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  input  logic [2:0]            m1_arprot,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]            m1_rresp,

  output logic                  s_arvalid,
  input  logic                  s_arready,
  output logic [ADDR_WIDTH-1:0] s_araddr,
  output logic [2:0]            s_arprot,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,

  output logic                  busy,
  output logic                  grant
);

  arb_state_t            state_q, state_d;
  master_id_t            grant_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [2:0]            arprot_q;
  logic                  gnt_valid;
  master_id_t            gnt_id;
  logic                  ar_hs;
  logic                  sel0, sel1;

`ifdef AXI_ARB_RR_EN
  master_id_t            last_q;
`endif

  rr_arbiter2 u_arb (
    .req       ({m1_arvalid, m0_arvalid}),
`ifdef AXI_ARB_RR_EN
    .last      (last_q),
`endif
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // FSM next state and AR-side ready; arready is only ever offered in IDLE.
  always_comb begin
    state_d    = state_q;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    ar_hs      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          m0_arready = (gnt_id == 1'b0);
          m1_arready = (gnt_id == 1'b1);
          ar_hs      = 1'b1;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (s_arready) state_d = DATA;
      end
      DATA: begin
        if (s_rvalid && s_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      state_q  <= IDLE;
      grant_q  <= 1'b1;
      araddr_q <= '0;
      arprot_q <= '0;
`ifdef AXI_ARB_RR_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      if (ar_hs) begin
        grant_q  <= gnt_id;
        araddr_q <= gnt_id[0] ? m1_araddr : m0_araddr;
        arprot_q <= gnt_id[0] ? m1_arprot : m0_arprot;
      end
`ifdef AXI_ARB_RR_EN
      if (state_q == DATA && s_rvalid && s_rready) last_q <= grant_q;
`endif
    end
  end

  assign s_arvalid = (state_q == ADDR);
  assign s_araddr  = araddr_q;
  assign s_arprot  = arprot_q;

  // R channel is a pure pass-through to the granted master; anything the memory
  // presents outside DATA (early or stale beats) is neither forwarded nor acked.
  assign sel0 = (state_q == DATA) && (grant_q == 1'b0);
  assign sel1 = (state_q == DATA) && (grant_q == 1'b1);

  assign m0_rvalid = sel0 & s_rvalid;
  assign m0_rdata  = sel0 ? s_rdata : '0;
  assign m0_rresp  = sel0 ? s_rresp : 2'b00;
  assign m1_rvalid = sel1 & s_rvalid;
  assign m1_rdata  = sel1 ? s_rdata : '0;
  assign m1_rresp  = sel1 ? s_rresp : 2'b00;
  assign s_rready  = (sel0 & m0_rready) | (sel1 & m1_rready);

  assign busy  = (state_q != IDLE);
  assign grant = grant_q[0];

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: two master models, a memory model,
// and a per-master scoreboard of expected read beats.
module tb_axi_read_arbiter;
  import axi_arb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } exp_t;

  logic          aclk = 1'b0;
  logic          areset;
  logic [1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
  logic [AW-1:0] m_araddr [2];
  logic [2:0]    m_arprot [2];
  logic [DW-1:0] m_rdata  [2];
  logic [1:0]    m_rresp  [2];
  logic          s_arvalid, s_arready, s_rvalid, s_rready;
  logic [AW-1:0] s_araddr;
  logic [2:0]    s_arprot;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          busy, grant;

  axi_read_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .m0_arvalid (m_arvalid[0]),
    .m0_arready (m_arready[0]),
    .m0_araddr  (m_araddr[0]),
    .m0_arprot  (m_arprot[0]),
    .m0_rvalid  (m_rvalid[0]),
    .m0_rready  (m_rready[0]),
    .m0_rdata   (m_rdata[0]),
    .m0_rresp   (m_rresp[0]),
    .m1_arvalid (m_arvalid[1]),
    .m1_arready (m_arready[1]),
    .m1_araddr  (m_araddr[1]),
    .m1_arprot  (m_arprot[1]),
    .m1_rvalid  (m_rvalid[1]),
    .m1_rready  (m_rready[1]),
    .m1_rdata   (m_rdata[1]),
    .m1_rresp   (m_rresp[1]),
    .s_arvalid  (s_arvalid),
    .s_arready  (s_arready),
    .s_araddr   (s_araddr),
    .s_arprot   (s_arprot),
    .s_rvalid   (s_rvalid),
    .s_rready   (s_rready),
    .s_rdata    (s_rdata),
    .s_rresp    (s_rresp),
    .busy       (busy),
    .grant      (grant)
  );

  initial forever #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory contents and responses are pure functions of the address.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  function automatic logic [1:0] mem_resp(input logic [AW-1:0] a);
    if (a[31:28] == 4'hb) return RESP_SLVERR;
    if (a[31:28] == 4'hd) return RESP_DECERR;
    return RESP_OKAY;
  endfunction

  // Master model state
  logic [AW-1:0] req_q [2][$];
  exp_t          exp_q [2][$];
  bit            cur_valid [2];
  logic [AW-1:0] cur_addr  [2];
  int            rv_cnt    [2];
  int            rready_hold [2];
  int            done      [2];
  int            wait_base [2];
  bit            hold_valid [2];
  logic [33:0]   hold_data [2];

  // Transaction tracking
  bit            txn_active, in_data, after_r;
  int            act_m, acc_age;
  logic [AW-1:0] acc_addr;
  int            accept_log [$];

  // Memory model state and knobs
  bit            mem_busy, mem_stale, mem_pres;
  int            mem_cnt, ar_wait, stale_cnt;
  logic [AW-1:0] mem_addr;
  int            mem_ar_stall, mem_r_delay;
  bit            early_rv, rand_mode;

  // Drive at posedge+1, observe handshakes at the following negedge.
  initial begin
    m_arvalid = '0;
    m_rready  = '0;
    for (int m = 0; m < 2; m++) begin
      m_araddr[m] = '0;
      m_arprot[m] = '0;
    end
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rresp   = '0;
    forever begin
      @(posedge aclk);
      #1;
      for (int m = 0; m < 2; m++) begin
        if (areset && !cur_valid[m] && req_q[m].size() > 0) begin
          exp_t e;
          cur_addr[m]  = req_q[m].pop_front();
          cur_valid[m] = 1'b1;
          e.data = mem_word(cur_addr[m]);
          e.resp = mem_resp(cur_addr[m]);
          exp_q[m].push_back(e);
          wait_base[m] = done[1-m];
        end
        m_arvalid[m] = cur_valid[m];
        m_araddr[m]  = cur_valid[m] ? cur_addr[m] : AW'($urandom);
        m_arprot[m]  = cur_addr[m][6:4];
        m_rready[m]  = rand_mode ? 1'($urandom_range(0, 1)) : (rv_cnt[m] >= rready_hold[m]);
      end
      if (acc_age < 1000) acc_age++;
      mem_pres = mem_busy && (mem_cnt == 0);
      if (mem_pres) begin
        s_rvalid = 1'b1;
        s_rdata  = mem_word(mem_addr);
        s_rresp  = mem_resp(mem_addr);
      end else begin
        s_rvalid = early_rv && s_arvalid;
        s_rdata  = DW'($urandom);
        s_rresp  = 2'($urandom_range(0, 3));
      end
      if (mem_busy && mem_cnt > 0) mem_cnt--;
      s_arready = !mem_busy &&
                  (rand_mode ? 1'($urandom_range(0, 1)) : (ar_wait >= mem_ar_stall));

      @(negedge aclk);
      if (!areset) begin
        for (int m = 0; m < 2; m++) begin
          exp_q[m].delete();
          cur_valid[m]  = 1'b0;
          rv_cnt[m]     = 0;
          hold_valid[m] = 1'b0;
        end
        txn_active = 1'b0;
        in_data    = 1'b0;
        after_r    = 1'b0;
        ar_wait    = 0;
        if (mem_busy) mem_stale = 1'b1;
      end else begin
        // Per-cycle invariants
        check_eq("busy", busy, txn_active);
        check_eq("s_arvalid", s_arvalid, txn_active && !in_data);
        check_eq("s_rready", s_rready, in_data ? m_rready[act_m] : 1'b0);
        if (txn_active) check_eq("arready_busy", m_arready, 2'b00);
        if (txn_active && acc_age >= 1) check_eq("grant", grant, act_m);
        for (int m = 0; m < 2; m++) begin
          bit sel;
          sel = in_data && (act_m == m);
          check_eq($sformatf("m%0d_rvalid", m), m_rvalid[m], sel && s_rvalid);
          if (!sel) check_eq($sformatf("m%0d_rdata_idle", m), {m_rresp[m], m_rdata[m]}, 34'd0);
          else check_eq($sformatf("m%0d_rdata_pass", m), {m_rresp[m], m_rdata[m]},
                        {s_rresp, s_rdata});
        end
        if (after_r) begin
          after_r = 1'b0;
          if (cur_valid[0] || cur_valid[1]) check_eq("turnaround", |m_arready, 1'b1);
        end

        // Memory-side address channel
        if (s_arvalid) begin
          if (acc_age == 1 && !in_data) check_eq("ar_latency", s_arvalid, 1'b1);
          check_eq("s_araddr", s_araddr, acc_addr);
          check_eq("s_arprot", s_arprot, acc_addr[6:4]);
        end
        if (txn_active && !in_data && acc_age == 1) check_eq("ar_issue", s_arvalid, 1'b1);
        if (s_arvalid && !s_arready) ar_wait++;
        else ar_wait = 0;
        if (s_arvalid && s_arready && !mem_busy) begin
          mem_busy  = 1'b1;
          mem_stale = 1'b0;
          mem_addr  = s_araddr;
          mem_cnt   = rand_mode ? int'($urandom_range(0, 3)) : mem_r_delay;
          if (txn_active) in_data = 1'b1;
        end

        // Memory-side data channel
        if (mem_pres && mem_stale) begin
          stale_cnt++;
          if (stale_cnt >= 3 || s_rready) begin
            mem_busy  = 1'b0;
            mem_stale = 1'b0;
            stale_cnt = 0;
          end
        end else if (mem_pres && s_rready) begin
          mem_busy = 1'b0;
        end

        // Master-side data channel: scoreboard
        for (int m = 0; m < 2; m++) begin
          if (m_rvalid[m] && m_rready[m]) begin
            if (exp_q[m].size() == 0) begin
              check_eq($sformatf("m%0d_r_unexpected", m), exp_q[m].size(), 1);
            end else begin
              exp_t e;
              e = exp_q[m].pop_front();
              check_eq($sformatf("m%0d_rdata", m), m_rdata[m], e.data);
              check_eq($sformatf("m%0d_rresp", m), m_rresp[m], e.resp);
            end
            done[m]++;
            txn_active    = 1'b0;
            in_data       = 1'b0;
            after_r       = 1'b1;
            rv_cnt[m]     = 0;
            hold_valid[m] = 1'b0;
          end else if (m_rvalid[m]) begin
            rv_cnt[m]++;
            if (hold_valid[m]) check_eq($sformatf("m%0d_rhold", m),
                                        {m_rresp[m], m_rdata[m]}, hold_data[m]);
            hold_valid[m] = 1'b1;
            hold_data[m]  = {m_rresp[m], m_rdata[m]};
          end
        end

        // Master-side address channel
        for (int m = 0; m < 2; m++) begin
          if (m_arvalid[m] && m_arready[m]) begin
            cur_valid[m] = 1'b0;
            txn_active   = 1'b1;
            in_data      = 1'b0;
            act_m        = m;
            acc_addr     = cur_addr[m];
            acc_age      = 0;
            accept_log.push_back(m);
`ifdef AXI_ARB_RR_EN
            check_eq($sformatf("m%0d_rr_fair", m), (done[1-m] - wait_base[m]) <= 1, 1'b1);
`endif
          end
        end
      end
    end
  end

  task automatic do_reset(input int cycles);
    @(posedge aclk);
    #2 areset = 1'b0;
    repeat (cycles) @(posedge aclk);
    #2 areset = 1'b1;
  endtask

  task automatic wait_done(input int m, input int target, input int budget);
    int n = 0;
    while (done[m] < target && n < budget) begin
      @(posedge aclk);
      n++;
    end
    check_eq($sformatf("m%0d_done", m), done[m], target);
  endtask

  initial begin
    int n;
    logic [AW-1:0] a;
    int exp_first;
    areset       = 1'b0;
    mem_ar_stall = 0;
    mem_r_delay  = 0;
    early_rv     = 1'b0;
    rand_mode    = 1'b0;
    rready_hold  = '{0, 0};

    // Reset values while held in reset (memory drives junk on s_rdata).
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_eq("rst_s_ar", {s_arvalid, s_arprot, s_araddr}, 36'd0);
    check_eq("rst_rvalid", m_rvalid, 2'b00);
    check_eq("rst_m0_r", {m_rresp[0], m_rdata[0]}, 34'd0);
    check_eq("rst_m1_r", {m_rresp[1], m_rdata[1]}, 34'd0);
    check_eq("rst_ctrl", {s_rready, busy, m_arready}, 4'b0000);
    check_eq("rst_grant", grant, 1'b1);
    @(posedge aclk);
    #2 areset = 1'b1;

    // Single m0 read.
    @(posedge aclk);
    req_q[0].push_back(32'h0000_0100);
    wait_done(0, 1, 50);

    // Simultaneous requests straight out of reset.
    do_reset(2);
    accept_log.delete();
    @(posedge aclk);
    req_q[0].push_back(32'h0000_0010);
    req_q[1].push_back(32'h0000_0020);
    wait_done(0, 2, 50);
    wait_done(1, 1, 50);
`ifdef AXI_ARB_RR_EN
    exp_first = 0;
`else
    exp_first = 1;
`endif
    check_eq("simul_count", accept_log.size(), 2);
    if (accept_log.size() >= 2) begin
      check_eq("simul_first", accept_log[0], exp_first);
      check_eq("simul_second", accept_log[1], 1 - exp_first);
    end

    // Backpressure on both AR (memory) and R (master 0), with early junk rvalid.
    mem_ar_stall   = 4;
    early_rv       = 1'b1;
    rready_hold[0] = 3;
    @(posedge aclk);
    req_q[0].push_back(32'h0000_0200);
    repeat (2) @(posedge aclk);
    req_q[1].push_back(32'h0000_0300);
    wait_done(0, 3, 80);
    wait_done(1, 2, 80);
    mem_ar_stall   = 0;
    early_rv       = 1'b0;
    rready_hold[0] = 0;

    // Error response routed to m1 only, then a normal m0 read.
    @(posedge aclk);
    req_q[1].push_back(32'hb000_0040);
    wait_done(1, 3, 50);
    req_q[0].push_back(32'h0000_0080);
    wait_done(0, 4, 50);

    // Reset while waiting for the data beat; the beat must never surface.
    mem_r_delay = 8;
    @(posedge aclk);
    req_q[1].push_back(32'h0000_0500);
    n = 0;
    while (!in_data && n < 50) begin
      @(posedge aclk);
      n++;
    end
    check_eq("mid_in_data", in_data, 1'b1);
    repeat (2) @(posedge aclk);
    do_reset(2);
    @(negedge aclk);
    check_eq("mid_busy", busy, 1'b0);
    check_eq("mid_rvalid", m_rvalid, 2'b00);
    n = 0;
    while (mem_busy && n < 50) begin
      @(posedge aclk);
      n++;
    end
    mem_r_delay = 0;
    req_q[1].push_back(32'h0000_0600);
    wait_done(1, 4, 50);

    // Sustained random traffic from both masters.
    rand_mode = 1'b1;
    @(posedge aclk);
    for (int i = 0; i < 100; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       a[31:28] = 4'hb;
        1:       a[31:28] = 4'hd;
        default: a[31:28] = 4'h0;
      endcase
      req_q[i % 2].push_back(a);
    end
    wait_done(0, 54, 3000);
    wait_done(1, 54, 3000);
    rand_mode = 1'b0;
    repeat (3) @(posedge aclk);
    check_eq("final_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Two-master AXI4-Lite read-channel arbiter sharing the single read port of `axi_memory` between the instruction cache (master 0) and the data cache (master 1). It accepts one address request at a time, forwards it to the memory, routes the returned beat back to the winning master, and then re-arbitrates. It sits between `i_cache`/data-cache refill ports and `axi_memory` port A. Write channels are out of scope.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: address width of all `araddr` ports.
- `DATA_WIDTH`, default 32: data width of all `rdata` ports.

Ports:
- `aclk` in 1: single clock. All logic is on the rising edge.
- `areset` in 1: asynchronous, active-low reset.
- `m0_arvalid` in 1, `m0_arready` out 1, `m0_araddr` in ADDR_WIDTH, `m0_arprot` in 3: master 0 (I-cache) read-address channel.
- `m0_rvalid` out 1, `m0_rready` in 1, `m0_rdata` out DATA_WIDTH, `m0_rresp` out 2: master 0 read-data channel.
- `m1_*` ports: the same set with the same directions and widths, for master 1 (D-cache).
- `s_arvalid` out 1, `s_arready` in 1, `s_araddr` out ADDR_WIDTH, `s_arprot` out 3: read-address channel to the memory.
- `s_rvalid` in 1, `s_rready` out 1, `s_rdata` in DATA_WIDTH, `s_rresp` in 2: read-data channel from the memory.
- `busy` out 1: a transaction is in progress (state is not IDLE).
- `grant` out 1: ID of the current or last granted master.

## Operation
- State machine `IDLE -> ADDR -> DATA -> IDLE`.
- **IDLE**
  - The grant is selected combinationally from `m0_arvalid`/`m1_arvalid`.
  - The winner sees `marready=1` in the same cycle. The loser sees `arready=0`.
  - On that handshake: latch `araddr`/`arprot` into `s_araddr`/`s_arprot`, register `grant`, and go to ADDR.
  - With no requests, stay in IDLE. All `arready` outputs are 0 in ADDR and DATA.
- **ADDR**
  - `s_arvalid=1` with the latched address and prot, held stable until `s_arready`.
  - On `s_arvalid && s_arready`: go to DATA.
- **DATA**
  - Pass-through to the granted master:
    - `s_rdata` and `s_rresp` go to the granted master's `rdata`/`rresp`.
    - `s_rvalid` goes to the granted master's `rvalid`.
    - The granted master's `rready` drives `s_rready`.
  - The non-granted master sees `rvalid=0`. Its `rdata`/`rresp` are driven to 0.
  - On `s_rvalid && s_rready`: update the last-granted register and go to IDLE.
- `rresp` is forwarded unmodified. SLVERR and DECERR do not change sequencing.
- Only one outstanding transaction. A request arriving while busy waits with `arvalid` held, as AXI requires.

## Timing
- Reset values:
  - State IDLE.
  - `s_arvalid=0`, `s_araddr=0`, `s_arprot=0`.
  - All `rvalid=0`, all `rdata`/`rresp` 0.
  - `s_rready=0`, `busy=0`.
  - `grant=1`, and last-granted = 1, so master 0 wins the first simultaneous request.
- Request accepted in cycle N gives `s_arvalid` in cycle N+1. The arbiter adds exactly one address-path cycle. The data path adds 0 cycles (combinational).
- Minimum turnaround: the R handshake in cycle M allows the next `arready` in cycle M+1. There is no back-to-back accept in the same cycle as R completion.
- Simultaneous `m0_arvalid` and `m1_arvalid` in IDLE: resolved per the Configuration section.
- `s_rvalid` asserted while in ADDR: ignored. It is not forwarded and `s_rready` stays 0.
- Reset asserted mid-transaction: immediate return to the reset values. Any memory beat in flight is dropped and never forwarded.
- `s_arready` high in IDLE: no effect.

## Configuration
- `AXI_ARB_RR_EN` defined: round-robin. On simultaneous requests, the master not granted last wins. The last-granted register updates on every R handshake.
- `AXI_ARB_RR_EN` undefined: fixed priority. Master 1 (D-cache) always wins simultaneous requests. The last-granted register is not used, and `grant` still reports the current winner.

## Structure
- Package `axi_arb_pkg` holds:
  - `arb_state_t` enum (`IDLE`, `ADDR`, `DATA`).
  - `master_id_t` (1 bit).
  - Response constants `RESP_OKAY=2'b00`, `RESP_SLVERR=2'b10`, `RESP_DECERR=2'b11`.
- One sub-module, `rr_arbiter2`: combinational 2-way grant from the request vector and last-granted ID. It contains the `AXI_ARB_RR_EN` selection.
- Top-level `axi_read_arbiter` holds the FSM, the address latch, and the R-channel mux.

## Test plan
- **Reset:** `areset=0` for 3 cycles -> all outputs at reset values. Release, `m0` reads 0x100 -> `s_araddr=0x100` one cycle after the accept, and `m0_rdata` equals the memory word.
- **Simultaneous requests:** `m0` reads 0x10 and `m1` reads 0x20, both with `arvalid` held.
  - With RR: `m0` is served first, then `m1`; `grant` goes 0 then 1.
  - Without RR: `m1` is served first.
- **Backpressure:** `s_arready` held low for 4 cycles -> `s_arvalid` and `s_araddr` stable throughout. `m0_rready` held low 3 cycles after `s_rvalid` -> `s_rready=0`, `m0_rdata` stable, no second request accepted.
- **Routing isolation:** `m1` transaction returns `rresp=2'b10` -> `m1_rresp=2'b10`, `m0_rvalid` stays 0, next request accepted normally.
- **Reset mid-transaction:** assert `areset` in DATA before `s_rvalid` -> state IDLE, no `rvalid` on either master after release, next `m1` request completes correctly.
- **Sustained traffic:** 100 random requests from both masters -> every request gets exactly one response with the correct data, and no master waits more than one transaction under RR.
